// File: rtl/systolic_west_feeder_if.sv
// rtl/systolic_west_feeder_if.sv - activation-vector handshake between buffer and west feeder
// Master drives the vector; slave (the feeder) returns ready.
interface systolic_west_feeder_if #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_last;
  logic [ROWS*DATA_W-1:0] in_data;

  modport master (output in_valid, in_data, in_last, input in_ready);
  modport slave  (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/systolic_west_feeder.sv
// rtl/systolic_west_feeder.sv - west-edge feeder: diagonal skew of activations and weight-switch wavefront
// Row r sees whatever the FSM produced in cycle T at cycle T+1+r.
module systolic_west_feeder #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_start_i,
  input  logic                   cmd_switch_i,
  systolic_west_feeder_if.slave  in_if,
  output logic [ROWS*DATA_W-1:0] row_input_o,
  output logic [ROWS-1:0]        row_valid_o,
  output logic [ROWS-1:0]        row_switch_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_W-1:0]       vec_count_o
);

  localparam int DW = $clog2(ROWS);

  typedef enum logic [1:0] {S_IDLE, S_SWITCH, S_STREAM, S_DRAIN} state_e;

  state_e            state_q;
  logic [DW-1:0]     drain_q;
  logic [CNT_W-1:0]  vec_count_q;
  logic              done_q;
  logic [ROWS-1:0]   valid_q;
  logic [ROWS-1:0]   switch_q;
  logic              accept;
  logic              switch_d;

  assign in_if.in_ready = (state_q == S_STREAM);
  assign accept         = in_if.in_valid && (state_q == S_STREAM);
  assign switch_d       = (state_q == S_SWITCH);
  assign busy_o         = (state_q != S_IDLE);
  assign done_o         = done_q;
  assign vec_count_o    = vec_count_q;
  assign row_valid_o    = valid_q;
  assign row_switch_o   = switch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      drain_q     <= '0;
      vec_count_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_start_i) begin
            vec_count_q <= '0;
            state_q     <= cmd_switch_i ? S_SWITCH : S_STREAM;
          end
        end
        S_SWITCH: state_q <= S_STREAM;
        S_STREAM: begin
          if (accept) begin
            if (vec_count_q != '1) vec_count_q <= vec_count_q + 1'b1;
            if (in_if.in_last) begin
              drain_q <= DW'(ROWS - 1);
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // done is registered, so raise it one cycle early to land when the counter reads 0
          if (drain_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            drain_q <= drain_q - 1'b1;
            if (drain_q == DW'(1)) done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      switch_q <= '0;
    end else begin
      valid_q  <= {valid_q[ROWS-2:0], accept};
      switch_q <= {switch_q[ROWS-2:0], switch_d};
    end
  end

  // Each row keeps only its own lane, delayed by r+1 registers
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [DATA_W-1:0] lane_q [r+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k <= r; k++) lane_q[k] <= '0;
      end else begin
        lane_q[0] <= accept ? in_if.in_data[r*DATA_W +: DATA_W] : '0;
        for (int k = 1; k <= r; k++) lane_q[k] <= lane_q[k-1];
      end
    end

    assign row_input_o[r*DATA_W +: DATA_W] = lane_q[r];
  end

endmodule

// File: tb/tb_systolic_west_feeder.sv
// tb/tb_systolic_west_feeder.sv - bench for systolic_west_feeder
// Directed table, hand sequences and random traffic against a timestamp-based tile model.
module tb_systolic_west_feeder;
  localparam int ROWS   = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int VW     = ROWS * DATA_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_start = 1'b0;
  logic             cmd_switch = 1'b0;
  logic [VW-1:0]    row_input;
  logic [ROWS-1:0]  row_valid;
  logic [ROWS-1:0]  row_switch;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] vec_count;

  systolic_west_feeder_if #(.ROWS(ROWS), .DATA_W(DATA_W)) act_if ();

  systolic_west_feeder #(.ROWS(ROWS), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_start_i  (cmd_start),
    .cmd_switch_i (cmd_switch),
    .in_if        (act_if),
    .row_input_o  (row_input),
    .row_valid_o  (row_valid),
    .row_switch_o (row_switch),
    .busy_o       (busy),
    .done_o       (done),
    .vec_count_o  (vec_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Tile model: what the FSM produced in each absolute cycle, plus tile timestamps
  bit [VW-1:0] pd [int];
  bit          pv [int];
  bit          ps [int];
  bit t_on    = 1'b0;
  int t_start = 0;
  bit t_sw    = 1'b0;
  int t_last  = -1;
  int t_cnt   = 0;
  int done_seen = 0;

  typedef struct {
    bit          start, sw, iv, il;
    logic [31:0] data;
    logic [3:0]  e_sw, e_val;
    logic [31:0] e_in;
    bit          e_done, e_busy, e_rdy;
    logic [3:0]  e_cnt;
  } vec_t;
  vec_t tbl [11];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit m_idle(int c);
    return !(t_on && c > t_start && (t_last < 0 || c <= t_last + ROWS));
  endfunction

  function automatic bit m_stream(int c);
    return t_on && (c >= t_start + 1 + int'(t_sw)) && (t_last < 0);
  endfunction

  task automatic model_check();
    logic [VW-1:0]   e_in;
    logic [ROWS-1:0] e_v;
    logic [ROWS-1:0] e_s;
    bit   [VW-1:0]   vec;
    e_in = '0; e_v = '0; e_s = '0;
    for (int r = 0; r < ROWS; r++) begin
      int t;
      t = cyc - 1 - r;
      if (pv.exists(t) && pv[t]) begin
        vec = pd[t];
        e_v[r] = 1'b1;
        e_in[r*DATA_W +: DATA_W] = vec[r*DATA_W +: DATA_W];
      end
      if (ps.exists(t) && ps[t]) e_s[r] = 1'b1;
    end
    check("m_row_input", 64'(row_input), 64'(e_in));
    check("m_row_valid", 64'(row_valid), 64'(e_v));
    check("m_row_switch", 64'(row_switch), 64'(e_s));
    check("m_busy", 64'(busy), 64'(!m_idle(cyc)));
    check("m_done", 64'(done), 64'(t_on && t_last >= 0 && cyc == t_last + ROWS));
    check("m_in_ready", 64'(act_if.in_ready), 64'(m_stream(cyc)));
    check("m_vec_count", 64'(vec_count), 64'(t_cnt));
  endtask

  task automatic model_update();
    if (m_stream(cyc) && act_if.in_valid) begin
      pv[cyc] = 1'b1;
      pd[cyc] = act_if.in_data;
      if (t_cnt < (1 << CNT_W) - 1) t_cnt++;
      if (act_if.in_last) t_last = cyc;
    end else if (m_idle(cyc) && cmd_start) begin
      t_on = 1'b1; t_start = cyc; t_sw = cmd_switch; t_last = -1; t_cnt = 0;
      if (cmd_switch) ps[cyc+1] = 1'b1;
    end
  endtask

  task automatic drive(bit s, bit sw, bit iv, bit il, logic [VW-1:0] d);
    cmd_start = s; cmd_switch = sw;
    act_if.in_valid = iv; act_if.in_last = il; act_if.in_data = d;
  endtask

  task automatic step();
    model_check();
    if (done) done_seen++;
    model_update();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_row_input"}, 64'(row_input), 64'd0);
    check({tag, "_row_valid"}, 64'(row_valid), 64'd0);
    check({tag, "_row_switch"}, 64'(row_switch), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_in_ready"}, 64'(act_if.in_ready), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    pv.delete(); pd.delete(); ps.delete();
    t_on = 1'b0; t_cnt = 0; t_last = -1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc += 2;
  endtask

  initial begin
    int tl;
    int d0;
    int exp_l;
    drive(0, 0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    check("reset_vec_count", 64'(vec_count), 64'd0);
    rst_n = 1'b1;

    // Switch tile of four vectors; lane r of vector k = 16*r + k
    tbl[0]  = '{1,1,0,0,32'h0,        4'b0000,4'b0000,32'h00000000,0,0,0,4'd0};
    tbl[1]  = '{0,0,0,0,32'h0,        4'b0000,4'b0000,32'h00000000,0,1,0,4'd0};
    tbl[2]  = '{0,0,1,0,32'h31211101, 4'b0001,4'b0000,32'h00000000,0,1,1,4'd0};
    tbl[3]  = '{0,0,1,0,32'h32221202, 4'b0010,4'b0001,32'h00000001,0,1,1,4'd1};
    tbl[4]  = '{0,0,1,0,32'h33231303, 4'b0100,4'b0011,32'h00001102,0,1,1,4'd2};
    tbl[5]  = '{0,0,1,1,32'h34241404, 4'b1000,4'b0111,32'h00211203,0,1,1,4'd3};
    tbl[6]  = '{0,0,0,0,32'h0,        4'b0000,4'b1111,32'h31221304,0,1,0,4'd4};
    tbl[7]  = '{0,0,0,0,32'h0,        4'b0000,4'b1110,32'h32231400,0,1,0,4'd4};
    tbl[8]  = '{0,0,0,0,32'h0,        4'b0000,4'b1100,32'h33240000,0,1,0,4'd4};
    tbl[9]  = '{0,0,0,0,32'h0,        4'b0000,4'b1000,32'h34000000,1,1,0,4'd4};
    tbl[10] = '{0,0,0,0,32'h0,        4'b0000,4'b0000,32'h00000000,0,0,0,4'd4};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].start, tbl[i].sw, tbl[i].iv, tbl[i].il, tbl[i].data);
      check("t_row_switch", 64'(row_switch), 64'(tbl[i].e_sw));
      check("t_row_valid", 64'(row_valid), 64'(tbl[i].e_val));
      check("t_row_input", 64'(row_input), 64'(tbl[i].e_in));
      check("t_done", 64'(done), 64'(tbl[i].e_done));
      check("t_busy", 64'(busy), 64'(tbl[i].e_busy));
      check("t_in_ready", 64'(act_if.in_ready), 64'(tbl[i].e_rdy));
      check("t_vec_count", 64'(vec_count), 64'(tbl[i].e_cnt));
      step();
    end

    // Single signed vector, no switch
    drive(1, 0, 0, 0, '0); step();
    drive(0, 0, 1, 1, 32'h807F807F); tl = cyc; step();
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 0, 0, '0);
      check("one_switch", 64'(row_switch), 64'd0);
      check("one_done", 64'(done), 64'(k == 4));
      if (k <= 4) begin
        exp_l = ((k - 1) % 2 == 1) ? -128 : 127;
        check("one_signed", 64'(int'($signed(row_input[(k-1)*DATA_W +: DATA_W]))), 64'(exp_l));
      end
      step();
    end

    // Valid toggling produces bubbles
    drive(1, 0, 0, 0, '0); step();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, (k % 2) == 0, k == 4, VW'($urandom)); step();
    end
    repeat (5) begin drive(0, 0, 0, 0, '0); step(); end

    // cmd_start hammered during STREAM and DRAIN
    drive(1, 1, 0, 0, '0); step();
    drive(1, 0, 0, 0, '0); step();
    d0 = done_seen;
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, k == 2, VW'($urandom)); step();
    end
    repeat (4) begin drive(1, 0, 0, 0, '0); step(); end
    drive(0, 0, 0, 0, '0);
    check("ign_vec_count", 64'(vec_count), 64'd3);
    check("ign_done_count", 64'(done_seen - d0), 64'd1);
    step();

    // Reset in the middle of a tile, then a clean tile
    drive(1, 1, 0, 0, '0); step();
    for (int k = 1; k < 4; k++) begin drive(0, 0, 1, 0, VW'($urandom)); step(); end
    do_reset();
    drive(1, 0, 0, 0, '0); step();
    drive(0, 0, 1, 0, VW'($urandom)); step();
    drive(0, 0, 1, 1, VW'($urandom)); step();
    repeat (5) begin drive(0, 0, 0, 0, '0); step(); end

    // Twenty vectors saturate a 4-bit counter
    drive(1, 0, 0, 0, '0); step();
    tl = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 1, i == 19, VW'($urandom));
      if (i == 19) tl = cyc;
      step();
    end
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, 0, 0, '0);
      check("sat_done", 64'(done), 64'(k == 4));
      step();
    end
    check("sat_vec_count", 64'(vec_count), 64'd15);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) == 0, $urandom % 2, $urandom % 2, ($urandom % 6) == 0, VW'($urandom));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/systolic_west_feeder.md
Name: systolic_west_feeder

Overview:
- Drives the west edge of the PE array: accepts row-vectors of activations through a valid/ready handshake and emits per-row input, valid and switch signals.
- Row r is skewed by r cycles so that data and weight-switch wavefronts enter the array diagonally.
- Issues a one-cycle weight-switch wavefront ahead of each tile, so every PE promotes its background weight before that tile's first activation arrives.
- Sits between the activation buffer and row 0..ROWS-1 of the array.

Parameters:
- ROWS, 4, number of array rows driven (>=2).
- DATA_W, 8, activation width per row (signed).
- CNT_W, 16, width of the per-tile vector counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_start  in  1  one-cycle pulse: begin a tile; sampled only in IDLE.
- cmd_switch  in  1  sampled with cmd_start: 1 = emit switch wavefront before data.
- in_valid  in  1  activation vector valid.
- in_ready  out  1  feeder can accept a vector this cycle.
- in_data  in  ROWS*DATA_W  vector; lane r = bits [r*DATA_W +: DATA_W].
- in_last  in  1  qualifies the final vector of the tile.
- row_input  out  ROWS*DATA_W  per-row activation to PE column 0.
- row_valid  out  ROWS  per-row valid.
- row_switch  out  ROWS  per-row weight switch.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: last vector has left row ROWS-1.
- vec_count  out  CNT_W  vectors accepted in the current or most recent tile; saturates at all-ones.

Behaviour:
- Reset (rst_n low, async): FSM=IDLE; all skew registers, row_input, row_valid, row_switch, done, in_ready, busy = 0; vec_count = 0.
- FSM states: IDLE, SWITCH, STREAM, DRAIN.
- IDLE:
  - cmd_start=1 and cmd_switch=1 -> SWITCH.
  - cmd_start=1 and cmd_switch=0 -> STREAM.
  - Entering a tile clears vec_count to 0.
- SWITCH (exactly 1 cycle):
  - Stage-0 switch input = 1, valid = 0.
  - Next state STREAM.
- STREAM:
  - in_ready = 1; a vector is accepted when in_valid && in_ready.
  - Accepted vector: stage-0 valid = 1, data = in_data; vec_count += 1, saturating.
  - Accept with in_last = 1 -> DRAIN with drain counter = ROWS-1.
  - Cycles with no accept inject bubbles: valid 0, data 0.
- DRAIN:
  - in_ready = 0; counter decrements each cycle.
  - done = 1 in the cycle the counter reads 0; next state IDLE.
- Skew pipeline:
  - Stage-0 register captures {data, valid, switch} from the FSM each cycle.
  - Row r output = stage-0 value delayed by r further registers.
  - Net latency: an item produced by the FSM in cycle T appears on row r at cycle T+1+r.
- done timing:
  - done is high in the same cycle row_valid[ROWS-1] carries the last vector, i.e. last accept at T gives done at T+ROWS.
  - The FSM is in IDLE in the following cycle.
- Switch spacing: the switch wavefront precedes the first valid on every row by >=1 cycle, since SWITCH never accepts data.
- Invalid lanes always drive row_input = 0; row_valid and row_switch are never X after reset.
- cmd_start outside IDLE is ignored, with no effect on state or counters.
- in_last accepted in the first STREAM cycle (1-vector tile) is legal: done at T+ROWS.
- in_valid while in_ready = 0 is not consumed; the upstream must hold its data.
- Reset asserted mid-tile immediately clears all outputs, including in-flight skew contents. No done is emitted for the aborted tile.
- busy is combinational from state; in_ready is high only in STREAM.

Test Plan:
- ROWS=4: reset, then cmd_start with cmd_switch=1 at cycle 0; SWITCH at cycle 1. Accept vectors {1,2,3,4} at cycles 2-5, last at cycle 5.
  - row_switch[r] pulses at cycle 2+r.
  - row 0 outputs lane-0 values at cycles 3-6; row 3 outputs at cycles 6-9.
  - done at cycle 9; vec_count=4.
- cmd_switch=0, single vector 0x7F/0x80 lanes with in_last -> row_switch stays 0 throughout. Row r shows its lane at T+1+r with signed value preserved; done at T+4.
- in_valid toggling 1,0,1,0 in STREAM -> bubble rows show valid=0 and input=0. Order of valid items is preserved on every row.
- cmd_start pulsed during STREAM and DRAIN -> ignored; vec_count unchanged; a single done.
- Assert rst_n low at cycle 4 of a tile -> all row_* outputs, busy and done = 0 immediately. After release, a new cmd_start runs a clean tile.
- CNT_W=4, stream 20 vectors -> vec_count saturates at 15; done still fires at last accept +4.
